// File: rtl/layer_meta_gate.sv
// rtl/layer_meta_gate.sv - frame-synchronous per-layer metadata gate with fixed-priority merge
module layer_meta_gate #(
    parameter int         N_CH         = 4,
    parameter int         RGB_W        = 8,
    parameter int         BLINK_FRAMES = 16,
    parameter logic [1:0] RST_MODE     = 2'b01
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    twoPlayer,
    input  logic [N_CH-1:0]         drawReqIn,
    input  logic [N_CH*RGB_W-1:0]   RGBIn,
    input  logic                    modeWrEn,
    input  logic [$clog2(N_CH)-1:0] modeWrSel,
    input  logic [1:0]              modeWrData,
    output logic                    drawingRequestOut,
    output logic [RGB_W-1:0]        RGBOut,
    output logic [$clog2(N_CH)-1:0] layerIdOut,
    output logic                    blinkPhase
);
    localparam int SEL_W = $clog2(N_CH);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(N_CH);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;

    logic [1:0]       r_shadow [N_CH];
    logic [1:0]       r_active [N_CH];
    logic             r_active_two;
    logic [CNT_W-1:0] r_cnt;
    logic             r_blink;

    logic [N_CH-1:0]  w_enable;
    logic [N_CH-1:0]  w_valid;
    logic             w_any;
    logic [SEL_W-1:0] w_win_id;
    logic [RGB_W-1:0] w_win_rgb;

    assign blinkPhase = r_blink;

    // Shadow modes: software writes land here; out-of-range selects are dropped.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < N_CH; i++) r_shadow[i] <= RST_MODE;
        end else if (modeWrEn && ({1'b0, modeWrSel} < SEL_LIMIT)) begin
            r_shadow[modeWrSel] <= modeWrData;
        end
    end

    // Active modes and game mode: latched only at frame start, taking the pre-write shadow.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < N_CH; i++) r_active[i] <= RST_MODE;
            r_active_two <= 1'b0;
        end else if (startOfFrame) begin
            r_active     <= r_shadow;
            r_active_two <= twoPlayer;
        end
    end

    // Blink timer: counts frames and flips the phase every BLINK_FRAMES frames.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_cnt   <= '0;
            r_blink <= 1'b1;
        end else if (startOfFrame) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Per-layer gate from the currently active mode, game mode and blink phase.
    always_comb begin
        w_enable = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (r_active[i])
                MODE_OFF:   w_enable[i] = 1'b0;
                MODE_ON:    w_enable[i] = 1'b1;
                MODE_BLINK: w_enable[i] = r_blink;
                default:    w_enable[i] = ~r_active_two;
            endcase
        end
        w_valid = drawReqIn & w_enable;
    end

    // Fixed priority: scan from the top so the lowest valid index is the last to be kept.
    always_comb begin
        w_any     = 1'b0;
        w_win_id  = '0;
        w_win_rgb = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_valid[i]) begin
                w_any     = 1'b1;
                w_win_id  = SEL_W'(i);
                w_win_rgb = RGBIn[i*RGB_W +: RGB_W];
            end
        end
    end

    // Output register: one-cycle latency, all-zero when nothing survives the gate.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            drawingRequestOut <= 1'b0;
            RGBOut            <= '0;
            layerIdOut        <= '0;
        end else begin
            drawingRequestOut <= w_any;
            RGBOut            <= w_win_rgb;
            layerIdOut        <= w_win_id;
        end
    end
endmodule

// File: doc/layer_meta_gate.md
Name: layer_meta_gate

Overview:
- Parametrised, registered successor to the single-channel metadata on/off filter in the display pipeline.
- Gates N_CH overlay layers (score, timer, lives, icons, ...) with a per-layer mode register.
- Mode changes and the game-mode (1P/2P) selection take effect only at frame boundaries, so a layer never tears mid-frame.
- Resolves surviving layers by fixed priority into one drawingRequest/RGB pair for the object mux.

Parameters:
N_CH, 4, number of layer channels (2..8).
RGB_W, 8, colour width per channel.
BLINK_FRAMES, 16, blink half-period in frames (>=1).
RST_MODE, 2'b01, reset mode loaded into every channel (ON).

Ports:
clk  in  1  pixel clock.
resetN  in  1  reset. Synchronous, active-low.
startOfFrame  in  1  one-cycle pulse at frame start.
twoPlayer  in  1  game-mode select (1 = 2-player); sampled at startOfFrame only.
drawReqIn  in  N_CH  per-layer drawing requests; bit i = layer i.
RGBIn  in  N_CH*RGB_W  per-layer colours; layer i in bits [i*RGB_W +: RGB_W].
modeWrEn  in  1  mode write strobe.
modeWrSel  in  $clog2(N_CH)  layer index to write.
modeWrData  in  2  mode value.
drawingRequestOut  out  1  registered merged request.
RGBOut  out  RGB_W  registered merged colour.
layerIdOut  out  $clog2(N_CH)  index of the winning layer.
blinkPhase  out  1  current blink phase (debug/observe).

Behaviour:
- Mode encoding per layer: 00 OFF (never drawn); 01 ON; 10 BLINK (drawn only when blinkPhase=1); 11 ON_1P (drawn as ON unless the active twoPlayer = 1, then suppressed).
- Shadow mode registers: modeWrEn=1 writes modeWrData into shadow[modeWrSel] on the clock edge. A modeWrSel >= N_CH write is ignored.
- Active mode registers and active twoPlayer: copied from shadow/twoPlayer on every cycle with startOfFrame=1. They are otherwise held.
- Simultaneous modeWrEn and startOfFrame:
  - The active registers take the pre-write shadow value.
  - The new value becomes active at the next startOfFrame.
- Blink timer, advanced only on startOfFrame:
  - Frame counter runs 0..BLINK_FRAMES-1.
  - On the startOfFrame with counter = BLINK_FRAMES-1, the counter returns to 0 and blinkPhase toggles.
  - With BLINK_FRAMES=1, blinkPhase toggles every frame.
- Gate: enable[i] = f(activeMode[i], blinkPhase, activeTwoPlayer). Use the blinkPhase value held before the current edge's update.
- Per-layer validity: valid[i] = drawReqIn[i] & enable[i].
- Priority: the lowest index with valid=1 wins.
- Output register, 1-cycle latency:
  - Any valid layer: drawingRequestOut=1, RGBOut=RGBIn of the winner, layerIdOut=winner index.
  - No valid layer: drawingRequestOut=0, RGBOut=0, layerIdOut=0.
- Reset (resetN=0 at a clock edge) overrides every other input, including one asserted mid-frame or mid-write:
  - shadow and active modes = RST_MODE; activeTwoPlayer = 0.
  - frame counter = 0; blinkPhase = 1.
  - drawingRequestOut = 0, RGBOut = 0, layerIdOut = 0.
- After reset release, outputs follow inputs from the next edge using the reset modes. No startOfFrame is needed first.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset then pass-through, with no writes: drawReqIn=4'b0100, RGBIn layer2=8'hE0 -> one cycle later drawingRequestOut=1, RGBOut=8'hE0, layerIdOut=2. During resetN=0 all outputs = 0.
2. Priority: drawReqIn=4'b1010, layer1=8'h1C, layer3=8'h03 -> RGBOut=8'h1C, layerIdOut=1. Then write layer1 OFF and pulse startOfFrame -> RGBOut=8'h03, layerIdOut=3.
3. Frame-boundary gating:
   - Write layer0 OFF mid-frame -> output unchanged until startOfFrame.
   - Write coincident with startOfFrame -> change visible only after the following startOfFrame.
4. 2-player suppression: layer2 mode 11, drawReqIn=4'b0100, RGB 8'hFF.
   - twoPlayer=1 between frames -> still drawn until startOfFrame, then drawingRequestOut=0, RGBOut=0.
   - twoPlayer=0 at the next startOfFrame -> drawn again.
5. Blink with BLINK_FRAMES=2: layer0 mode 10, drawReqIn=1 -> blinkPhase toggles every 2 frames, and drawingRequestOut follows 1,1,0,0,1,1 across consecutive frames.
6. Reset mid-operation: assert resetN=0 during blinkPhase=0 with layers OFF -> after release all layers ON, blinkPhase=1, counter restarts at 0. An out-of-range modeWrSel write (N_CH=3, sel=3) changes nothing.
